// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one uart_tx serializer between NUM_REQ byte-stream
// requesters; packets are atomic and a stalled owner loses its grant after TIMEOUT cycles.
module uart_tx_arb #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 11
) (
  input  logic                   sclk,
  input  logic                   s_rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ack,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [7:0]             tx_data,
  output logic                   tx_trig,
  input  logic                   tx_done,
  output logic                   err_timeout
);

  localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CAND_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  state_t             state, state_n;
  logic [IDX_W-1:0]   cur_idx, idx_n;
  logic [IDX_W-1:0]   rr_ptr, rr_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               last_r, last_n;
  logic [NUM_REQ-1:0] gnt_n, ack_n;
  logic [7:0]         data_n;
  logic               trig_n, err_n;

  logic               pick_vld;
  logic [IDX_W-1:0]   pick_idx;
  logic [CAND_W-1:0]  cand;
  logic [7:0]         cur_data;
  logic               cur_valid, cur_last;
  logic [IDX_W-1:0]   next_ptr;

  // First valid requester searching upward from rr_ptr, wrapping at NUM_REQ
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr} + CAND_W'(i);
      if (cand >= CAND_W'(NUM_REQ)) cand = cand - CAND_W'(NUM_REQ);
      if (!pick_vld && req_valid[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand[IDX_W-1:0];
      end
    end
  end

  // Owner's request lines
  always_comb begin
    cur_data  = '0;
    cur_valid = 1'b0;
    cur_last  = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (cur_idx == IDX_W'(i)) begin
        cur_data  = req_data[8*i +: 8];
        cur_valid = req_valid[i];
        cur_last  = req_last[i];
      end
    end
  end

  assign next_ptr = (cur_idx == IDX_LAST) ? '0 : cur_idx + IDX_W'(1);

  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst) begin
      state       <= IDLE;
      cur_idx     <= '0;
      rr_ptr      <= '0;
      cnt         <= '0;
      last_r      <= 1'b0;
      gnt         <= '0;
      req_ack     <= '0;
      tx_data     <= 8'h00;
      tx_trig     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_n;
      cur_idx     <= idx_n;
      rr_ptr      <= rr_n;
      cnt         <= cnt_n;
      last_r      <= last_n;
      gnt         <= gnt_n;
      req_ack     <= ack_n;
      tx_data     <= data_n;
      tx_trig     <= trig_n;
      err_timeout <= err_n;
    end
  end

  // Next state and next registered outputs
  always_comb begin
    state_n = state;
    idx_n   = cur_idx;
    rr_n    = rr_ptr;
    cnt_n   = cnt;
    last_n  = last_r;
    gnt_n   = gnt;
    ack_n   = '0;
    data_n  = tx_data;
    trig_n  = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          idx_n   = pick_idx;
          gnt_n   = NUM_REQ'(1) << pick_idx;
          cnt_n   = '0;
          state_n = SEND;
        end
      end
      SEND: begin
        if (cur_valid) begin
          trig_n  = 1'b1;
          data_n  = cur_data;
          ack_n   = gnt;
          last_n  = cur_last;
          cnt_n   = '0;
          state_n = WAIT;
        end else if (cnt == CNT_MAX) begin
          // Owner stalled mid-packet: revoke and demote it
          err_n   = 1'b1;
          gnt_n   = '0;
          rr_n    = next_ptr;
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      WAIT: begin
        if (tx_done) begin
          if (last_r) begin
            gnt_n   = '0;
            rr_n    = next_ptr;
            state_n = IDLE;
          end else begin
            state_n = SEND;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
